// File: rtl/magnitude_sched_pkg.sv
// Shared types and helpers for the magnitude scheduler and its arbiter.
package magnitude_sched_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    // Index width that never collapses to zero bits for n <= 1.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/magnitude.sv
// Combinational vectoring-mode CORDIC magnitude, gain-compensated, truncating.
// Inputs are signed, output is the unsigned magnitude in the same Q format.
module magnitude #(
    parameter int WIDTH           = 17,
    parameter int FRACTIONAL_BITS = 12,
    parameter int ITERATIONS      = 16
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    output logic        [WIDTH-1:0] out
);

    localparam int  G    = 4;
    localparam int  IW   = WIDTH + 2 + G;
    localparam int  KB   = FRACTIONAL_BITS + 4;
    localparam real KR   = 0.6072529350088813 * (2.0 ** KB);
    localparam int  KINV = int'(KR);

    logic signed [IW-1:0]    xs, ys, xt;
    logic        [IW+KB-1:0] prod;

    // Guard bits keep the per-iteration truncation well below one output LSB.
    always_comb begin
        xs = {{(IW-WIDTH){x[WIDTH-1]}}, x} <<< G;
        ys = {{(IW-WIDTH){y[WIDTH-1]}}, y} <<< G;
        xt = '0;
        if (xs[IW-1]) xs = -xs;
        for (int i = 0; i < ITERATIONS; i++) begin
            xt = xs;
            if (!ys[IW-1]) begin
                xs = xs + (ys >>> i);
                ys = ys - (xt >>> i);
            end else begin
                xs = xs - (ys >>> i);
                ys = ys + (xt >>> i);
            end
        end
        prod = (IW+KB)'($unsigned(xs)) * (IW+KB)'(KINV);
    end

    assign out = WIDTH'(prod >> (KB + G));

endmodule

// File: rtl/magnitude_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req at or above ptr, wrapping.
module magnitude_rr_arbiter import magnitude_sched_pkg::*; #(
    parameter  int NUM_REQ = 3,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic found;
    int   k;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (en && !found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/magnitude_scheduler.sv
// Time-shares one combinational magnitude CORDIC between NUM_REQ requesters,
// round-robin, with held operands and an ID-tagged valid/ready response.
module magnitude_scheduler import magnitude_sched_pkg::*; #(
    parameter  int WIDTH           = 17,
    parameter  int FRACTIONAL_BITS = 12,
    parameter  int ITERATIONS      = 16,
    parameter  int NUM_REQ         = 3,
    parameter  int SETTLE_CYCLES   = 2,
    localparam int ID_W            = id_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]  req_x,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]  req_y,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [WIDTH-1:0]               resp_mag,
    output logic [ID_W-1:0]                resp_id,
    output logic                           busy
);

    localparam int CNT_W = id_width(SETTLE_CYCLES);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr, id_reg, gnt_idx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   x_reg, y_reg, mag_out;
    logic [NUM_REQ-1:0] gnt;

    // Grants only from IDLE; rst gating keeps req_ready low while reset is held.
    magnitude_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      ((state == IDLE) && !rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Multicycle path: x_reg/y_reg -> resp_mag is allowed SETTLE_CYCLES clocks;
    // the operands never change between accept and the sampling edge.
    magnitude #(
        .WIDTH           (WIDTH),
        .FRACTIONAL_BITS (FRACTIONAL_BITS),
        .ITERATIONS      (ITERATIONS)
    ) u_mag (
        .x   (x_reg),
        .y   (y_reg),
        .out (mag_out)
    );

    assign req_ready = gnt;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            id_reg     <= '0;
            resp_valid <= 1'b0;
            resp_mag   <= '0;
            resp_id    <= '0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    x_reg  <= req_x[gnt_idx];
                    y_reg  <= req_y[gnt_idx];
                    id_reg <= gnt_idx;
                    rr_ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
                    cnt    <= CNT_W'(SETTLE_CYCLES-1);
                    state  <= SETTLE;
                end
                SETTLE: if (cnt == '0) begin
                    resp_mag   <= mag_out;
                    resp_id    <= id_reg;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_magnitude_scheduler.sv
// Bench for magnitude_scheduler: default build plus a SETTLE_CYCLES=1, NUM_REQ=2 build.
module tb_magnitude_scheduler;

    localparam int W = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [2:0]       req_valid, req_ready;
    logic [2:0][W-1:0] req_x, req_y;
    logic             resp_valid, resp_ready, busy;
    logic [W-1:0]     resp_mag;
    logic [1:0]       resp_id;

    logic [1:0]       v2, rdy2;
    logic [1:0][W-1:0] x2, y2;
    logic             resp_valid2, rr2, busy2;
    logic [W-1:0]     mag2;
    logic [0:0]       id2;

    int total = 0, bad = 0;
    int opx[3], opy[3], op2x[2], op2y[2];

    magnitude_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_mag(resp_mag), .resp_id(resp_id), .busy(busy)
    );

    magnitude_scheduler #(.NUM_REQ(2), .SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
        .req_x(x2), .req_y(y2), .resp_valid(resp_valid2), .resp_ready(rr2),
        .resp_mag(mag2), .resp_id(id2), .busy(busy2)
    );

    function automatic int ref_mag(input int x, input int y);
        real r;
        r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        return int'($floor(r));
    endfunction

    function automatic int exp_grant(input logic [2:0] mask, input int ptr);
        int k;
        for (int i = 0; i < 3; i++) begin
            k = (ptr + i) % 3;
            if (mask[k]) return k;
        end
        return -1;
    endfunction

    function automatic int rnd_op();
        return int'($urandom_range(0, 38000)) - 19000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input int x, input int y);
        opx[k] = x; opy[k] = y;
        req_x[k] = W'(x); req_y[k] = W'(y);
    endtask

    // Drives one transaction on the main DUT (resp_ready assumed high); observes only.
    task automatic run_txn(input bit hold, output int gid, output int lat, output int mag,
                           output int id, output int readycnt, output int maxhot, output bit to);
        gid = -1; lat = 0; mag = 0; id = 0; readycnt = 0; maxhot = 0; to = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            if ($countones(req_ready) > maxhot) maxhot = $countones(req_ready);
            if (|(req_valid & req_ready)) begin
                for (int k = 0; k < 3; k++) if (req_ready[k]) gid = k;
                readycnt++;
                break;
            end
            step();
        end
        if (gid < 0) begin to = 1'b1; return; end
        step();
        if (!hold) req_valid[gid] = 1'b0;
        while (!resp_valid && lat < 20) begin
            if (req_ready[gid]) readycnt++;
            if ($countones(req_ready) > maxhot) maxhot = $countones(req_ready);
            step();
            lat++;
        end
        if (!resp_valid) begin to = 1'b1; return; end
        mag = int'(resp_mag); id = int'(resp_id);
        if (resp_ready) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 3'b111; resp_ready = 1'b0; v2 = '0; rr2 = 1'b1;
        for (int k = 0; k < 3; k++) load(k, 0, 0);
        x2 = '0; y2 = '0;
        step(); step();
        total++;
        if (resp_valid !== 1'b0 || resp_mag !== '0 || resp_id !== '0 || req_ready !== 3'b000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b mag=%0d id=%0d rdy=%b busy=%b want all zero",
                     resp_valid, resp_mag, resp_id, req_ready, busy);
        end
        total++;
        if (resp_valid2 !== 1'b0 || rdy2 !== 2'b00 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs_b: got v=%b rdy=%b busy=%b want 0", resp_valid2, rdy2, busy2);
        end
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int gid, lat, mag, id, rc, mh; bit to;
        load(0, 12288, 16384);
        resp_ready = 1'b1; req_valid = 3'b001;
        run_txn(1'b0, gid, lat, mag, id, rc, mh, to);
        total++;
        if (to) begin bad++; $display("FAIL single_timeout: got timeout want response"); return; end
        total++;
        if (gid != 0 || rc != 1) begin
            bad++; $display("FAIL single_grant: got gid=%0d ready_cycles=%0d want 0 and 1", gid, rc);
        end
        total++;
        if (lat != 2) begin bad++; $display("FAIL single_latency: got %0d want 2", lat); end
        total++;
        if (mag < 20480 - 8 || mag > 20480 + 8 || id != 0) begin
            bad++; $display("FAIL single_result: got mag=%0d id=%0d want 20480+-8 id=0", mag, id);
        end
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_one_cycle_resp: got v=%b busy=%b want 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_quadrants();
        int qx[4] = '{-12288, 12288, -12288, 0};
        int qy[4] = '{16384, -16384, -16384, 0};
        int gid, lat, mag, id, rc, mh, r, x, y, e, tol; bit to;
        resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            r = int'($urandom_range(0, 2));
            if (i < 4) begin x = qx[i]; y = qy[i]; end
            else begin x = rnd_op(); y = rnd_op(); end
            load(r, x, y);
            req_valid = 3'(1 << r);
            run_txn(1'b0, gid, lat, mag, id, rc, mh, to);
            e = ref_mag(x, y);
            tol = (x == 0 && y == 0) ? 0 : 8;
            total++;
            if (to || gid != r || id != r || mag < e - tol || mag > e + tol) begin
                bad++;
                $display("FAIL quadrant_%0d: got to=%0d gid=%0d id=%0d mag=%0d want id=%0d mag=%0d+-%0d (x=%0d y=%0d)",
                         i, to, gid, id, mag, r, e, tol, x, y);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int gid, lat, mag, id, rc, mh, ex, ptr; bit to;
        logic [2:0] mask;
        rst = 1'b1; step(); rst = 1'b0;
        ptr = 0;
        for (int k = 0; k < 3; k++) load(k, rnd_op(), rnd_op());
        resp_ready = 1'b1; req_valid = 3'b111;
        for (int t = 0; t < 14; t++) begin
            if (t < 6) mask = 3'b111;
            else mask = 3'($urandom_range(1, 7));
            req_valid = mask;
            ex = (t < 6) ? (t % 3) : exp_grant(mask, ptr);
            run_txn(1'b1, gid, lat, mag, id, rc, mh, to);
            total++;
            if (to || gid != ex || id != gid) begin
                bad++;
                $display("FAIL rr_order_%0d: got to=%0d gid=%0d id=%0d want gid=id=%0d (mask=%b)", t, to, gid, id, ex, mask);
            end
            total++;
            if (mh > 1 || rc != 1) begin
                bad++; $display("FAIL rr_onehot_%0d: got max_ready_bits=%0d ready_cycles=%0d want <=1 and 1", t, mh, rc);
            end
            if (gid >= 0) begin
                total++;
                if (mag < ref_mag(opx[gid], opy[gid]) - 8 || mag > ref_mag(opx[gid], opy[gid]) + 8) begin
                    bad++; $display("FAIL rr_mag_%0d: got %0d want %0d+-8", t, mag, ref_mag(opx[gid], opy[gid]));
                end
            end
            ptr = (ex + 1) % 3;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int c, m0, i0; bit to;
        load(0, rnd_op(), rnd_op());
        load(1, int'($urandom_range(4000, 19000)), int'($urandom_range(4000, 19000)));
        resp_ready = 1'b0; req_valid = 3'b001;
        #1; c = 0;
        while (!req_ready[0] && c < 20) begin step(); c++; end
        total++;
        if (!req_ready[0]) begin bad++; $display("FAIL bp_grant0: got ready=%b want 001", req_ready); return; end
        step();
        req_valid = 3'b010;
        c = 0;
        while (!resp_valid && c < 20) begin step(); c++; end
        total++;
        if (!resp_valid || resp_id !== 2'd0 ||
            int'(resp_mag) < ref_mag(opx[0], opy[0]) - 8 || int'(resp_mag) > ref_mag(opx[0], opy[0]) + 8) begin
            bad++;
            $display("FAIL bp_resp0: got v=%b id=%0d mag=%0d want 1 0 %0d+-8", resp_valid, resp_id, resp_mag, ref_mag(opx[0], opy[0]));
        end
        m0 = int'(resp_mag); i0 = int'(resp_id);
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (resp_valid !== 1'b1 || int'(resp_mag) != m0 || int'(resp_id) != i0 || busy !== 1'b1 || req_ready !== 3'b000) begin
                bad++;
                $display("FAIL bp_hold_%0d: got v=%b mag=%0d id=%0d busy=%b rdy=%b want 1 %0d %0d 1 000",
                         k, resp_valid, resp_mag, resp_id, busy, req_ready, m0, i0);
            end
        end
        resp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 3'b000) begin bad++; $display("FAIL bp_no_grant_at_resp: got rdy=%b want 000", req_ready); end
        step();
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 3'b010) begin
            bad++; $display("FAIL bp_release: got v=%b rdy=%b want 0 010", resp_valid, req_ready);
        end
        step();
        req_valid = '0;
        c = 0;
        while (!resp_valid && c < 20) begin step(); c++; end
        to = !resp_valid;
        total++;
        if (to || resp_id !== 2'd1 ||
            int'(resp_mag) < ref_mag(opx[1], opy[1]) - 8 || int'(resp_mag) > ref_mag(opx[1], opy[1]) + 8) begin
            bad++;
            $display("FAIL bp_resp1: got to=%0d id=%0d mag=%0d want id=1 mag=%0d+-8", to, resp_id, resp_mag, ref_mag(opx[1], opy[1]));
        end
        step();
    endtask

    task automatic test_reset_mid();
        int c, gid, lat, mag, id, rc, mh; bit to;
        load(1, 12288, 16384);
        resp_ready = 1'b1; req_valid = 3'b010;
        #1; c = 0;
        while (!req_ready[1] && c < 20) begin step(); c++; end
        total++;
        if (!req_ready[1]) begin bad++; $display("FAIL rst_mid_grant: got rdy=%b want 010", req_ready); return; end
        step();
        req_valid = '0;
        step();
        rst = 1'b1; req_valid = 3'b111;
        #1;
        total++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 3'b000 || resp_mag !== '0 || resp_id !== '0) begin
            bad++;
            $display("FAIL rst_mid_async: got busy=%b v=%b rdy=%b mag=%0d id=%0d want all zero",
                     busy, resp_valid, req_ready, resp_mag, resp_id);
        end
        step();
        rst = 1'b0; req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL rst_mid_no_resp_%0d: got v=%b busy=%b want 0 0", k, resp_valid, busy);
            end
        end
        load(0, 3000, -4000);
        req_valid = 3'b111;
        #1;
        total++;
        if (req_ready !== 3'b001) begin bad++; $display("FAIL rst_mid_ptr: got rdy=%b want 001", req_ready); end
        run_txn(1'b0, gid, lat, mag, id, rc, mh, to);
        req_valid = '0;
        total++;
        if (to || gid != 0 || id != 0 || mag < 5000 - 8 || mag > 5000 + 8) begin
            bad++; $display("FAIL rst_mid_next: got to=%0d gid=%0d id=%0d mag=%0d want 0 0 5000+-8", to, gid, id, mag);
        end
    endtask

    task automatic test_fast_build();
        int acc_q[$], gid_q[$];
        int edge_n = 0, last_acc = -1, nresp = 0, exp_id = 0, g, a, gq, e;
        for (int k = 0; k < 2; k++) begin
            op2x[k] = rnd_op(); op2y[k] = rnd_op();
            x2[k] = W'(op2x[k]); y2[k] = W'(op2y[k]);
        end
        rr2 = 1'b1; v2 = 2'b11;
        #1;
        for (int c = 0; c < 60 && nresp < 6; c++) begin
            if (resp_valid2) begin
                total++;
                if (acc_q.size() == 0) begin
                    bad++; $display("FAIL fast_spurious_resp: got resp with no accept want none");
                end else begin
                    a = acc_q.pop_front(); gq = gid_q.pop_front();
                    e = ref_mag(op2x[gq], op2y[gq]);
                    if (edge_n - a != 1 || int'(id2) != gq || int'(mag2) < e - 8 || int'(mag2) > e + 8) begin
                        bad++;
                        $display("FAIL fast_resp_%0d: got lat=%0d id=%0d mag=%0d want 1 %0d %0d+-8",
                                 nresp, edge_n - a, id2, mag2, gq, e);
                    end
                end
                nresp++;
            end
            if (|(v2 & rdy2)) begin
                g = rdy2[1] ? 1 : 0;
                total++;
                if (g != exp_id || (last_acc >= 0 && (edge_n + 1) - last_acc != 3)) begin
                    bad++;
                    $display("FAIL fast_accept: got id=%0d spacing=%0d want %0d 3", g, (edge_n + 1) - last_acc, exp_id);
                end
                last_acc = edge_n + 1;
                acc_q.push_back(edge_n + 1); gid_q.push_back(g);
                exp_id ^= 1;
            end
            step();
            edge_n++;
        end
        v2 = '0;
        total++;
        if (nresp != 6) begin bad++; $display("FAIL fast_count: got %0d responses want 6", nresp); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_quadrants();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_fast_build();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/magnitude_scheduler.md
Name: magnitude_scheduler

Overview:
- Time-shares one instance of the existing combinational `magnitude` CORDIC block between NUM_REQ requesters, for example the current-vector and voltage-vector limiters in the FOC loop.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- Operands are registered and held stable for SETTLE_CYCLES, so the unrolled CORDIC can be constrained as a multicycle path.
- The result is returned with a requester ID on a valid/ready response port.

Parameters:
- WIDTH, 17, operand/result width (signed fixed point in, unsigned magnitude out).
- FRACTIONAL_BITS, 12, fractional bits passed to `magnitude`.
- ITERATIONS, 16, CORDIC iterations passed to `magnitude`.
- NUM_REQ, 3, number of requesters (≥2).
- SETTLE_CYCLES, 2, clock cycles operands are held before the result is sampled (≥1).
- ID_W, $clog2(NUM_REQ), localparam, width of the requester ID.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_x  in  NUM_REQ×WIDTH  per-requester x operand (signed).
- req_y  in  NUM_REQ×WIDTH  per-requester y operand (signed).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_mag  out  WIDTH  |(x,y)| in the same Q format as the operands.
- resp_id  out  ID_W  index of the requester that owns resp_mag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, rr_ptr=0, settle counter=0.
  - Operand registers cleared to 0.
  - resp_valid=0, resp_mag=0, resp_id=0, req_ready=0, busy=0.
  - Reset mid-operation discards any in-flight request without a response. A requester that was granted but not answered must re-request.
- FSM states are IDLE, SETTLE and RESP.
- IDLE:
  - The grant is combinational: the first asserted req_valid searching upward from rr_ptr, wrapping at NUM_REQ-1→0.
  - req_ready[g]=1 only for the granted index; all other bits are 0. No grant is made if no req_valid is asserted.
  - On a handshake edge T:
    - x_reg/y_reg ← req_x[g]/req_y[g].
    - id_reg ← g.
    - rr_ptr ← g+1 (mod NUM_REQ).
    - counter ← SETTLE_CYCLES-1.
    - state → SETTLE.
- SETTLE:
  - `magnitude` is driven only from x_reg/y_reg; req_ready=0.
  - The counter decrements each cycle.
  - At the edge where the counter is 0: resp_mag ← magnitude.out, resp_id ← id_reg, resp_valid ← 1, state → RESP.
  - Latency: resp_valid is first high after edge T+SETTLE_CYCLES.
- RESP:
  - resp_valid, resp_mag and resp_id are held stable until resp_ready=1.
  - On a handshake edge: resp_valid ← 0, state → IDLE.
  - req_ready=0 throughout RESP. No new grant is made in the same cycle as the response handshake.
  - Minimum request spacing is SETTLE_CYCLES+2 cycles.
- Fairness: a requester that holds req_valid high is granted within NUM_REQ transactions.
- Requesters may drop req_valid before they are granted; the scheduler carries no state for ungranted requests.
- Arithmetic:
  - Operands are passed unchanged to `magnitude`.
  - The result is the unsigned magnitude, truncated by `magnitude`.
  - No saturation is applied. Operands with |x|,|y| ≤ 2^(WIDTH-2)/1.65 must not overflow.
- Simultaneous events:
  - Several req_valid high at once: the grant follows rr_ptr.
  - req_valid rising in SETTLE or RESP: the request waits.
  - resp_ready held high permanently: the response lasts exactly 1 cycle.

Decomposition:
- Package magnitude_sched_pkg holds:
  - the state enum {IDLE, SETTLE, RESP};
  - the function id_width(n)=$clog2(n), returning ≥1.
- Sub-module magnitude_rr_arbiter(NUM_REQ) takes req, ptr and en, and returns a one-hot grant plus its index. It is combinational and reused for future shared datapaths.
- The `magnitude` instance lives in magnitude_scheduler. The multicycle constraint (SETTLE_CYCLES) is documented next to the instance.

Test Plan:
- Single request: r0 sends x=12288 (3.0), y=16384 (4.0), resp_ready=1.
  - req_ready[0] is high for exactly 1 cycle.
  - resp_valid rises 2 edges after the accept.
  - resp_mag=20480±8 (5.0) and resp_id=0.
- Signed quadrants: (-12288,16384), (12288,-16384) and (-12288,-16384) each give 20480±8. (0,0) gives 0.
- Round-robin: all three req_valid held high for 6 transactions.
  - Grant order is 0,1,2,0,1,2.
  - Each resp_id matches its request.
  - At most one req_ready bit is high in any cycle.
- Back-pressure: resp_ready=0 for 10 cycles after resp_valid.
  - resp_mag and resp_id stay stable and busy=1.
  - No req_ready is asserted while r1 is pending.
  - Raising resp_ready completes the transfer; r1 is granted in the following IDLE cycle.
- Reset mid-SETTLE: assert rst one cycle after accept.
  - All outputs go to reset values immediately, with no clock edge needed.
  - No response appears after release.
  - The next grant starts from r0.
- SETTLE_CYCLES=1, NUM_REQ=2 build: a continuous request stream gives accept→resp_valid in 1 edge, 3-cycle spacing, and alternating IDs.
